// File: rtl/fp_pkg.sv
// Shared fp24 field widths, constants and pipeline record types.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 15;
  localparam int BIAS  = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Packed fp24: {sign, exp[7:0], man[14:0]}.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp24_t;

  localparam fp24_t FP24_PZERO = '0;

  // Stage A record: everything stage B needs to shift, adjust and pack.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [15:0]      mant;     // sub_mant, or add_mant[15:0] on the sum path
    logic             carry;    // add_mant[16]
    logic             eff_sub;
    logic [4:0]       lzc;      // leading zeros of sub_mant (16 = cancellation)
    logic             is_inf;   // exp_i == 255
    logic             is_zin;   // exp_i == 0
  } stg_a_t;

endpackage

// File: rtl/fp_lzc16.sv
// Combinational 16-bit leading-zero counter; returns 16 for an all-zero input.
module fp_lzc16 (
  input  logic [15:0] din,
  output logic [4:0]  cnt
);

  // Scan LSB->MSB so the highest set bit wins.
  always_comb begin
    cnt = 5'd16;
    for (int i = 0; i < 16; i++)
      if (din[i]) cnt = 5'(15 - i);
  end

endmodule

// File: rtl/fp_std_1.sv
// fp24 add/sub second stage: path select, normalise, over/underflow, pack.
// Two register stages with valid/ready back-pressure.
module fp_std_1 #(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             sign_i,
  input  logic [7:0]       exp_i,
  input  logic [16:0]      add_mant_i,
  input  logic [15:0]      sub_mant_i,
  input  logic             eff_sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             unf_o
);
  import fp_pkg::*;

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic            a_adv, b_adv;
  logic [4:0]      lzc;
  stg_a_t          a_d, a_q;
  fp24_t           res_d, res_q;
  logic            z_d, o_d, u_d;
  logic            z_q, o_q, u_q;
  logic [8:0]      e_inc;
  logic [15:0]     shifted;

  // Stage B drains on downstream ready; A moves whenever B can take it.
  assign b_adv   = !vld_pipe[2] || ready_i;
  assign a_adv   = !vld_pipe[1] || b_adv;
  assign ready_o = a_adv;

  fp_lzc16 u_lzc (.din(sub_mant_i), .cnt(lzc));

  // Stage A decode: capture path select, lzc, carry and special inputs.
  always_comb begin
    a_d         = '0;
    a_d.sign    = sign_i;
    a_d.exp     = exp_i;
    a_d.mant    = eff_sub_i ? sub_mant_i : add_mant_i[15:0];
    a_d.carry   = add_mant_i[16];
    a_d.eff_sub = eff_sub_i;
    a_d.lzc     = lzc;
    a_d.is_inf  = (exp_i == EXP_MAX);
    a_d.is_zin  = (exp_i == '0);
  end

  // Stage B compute: normalise shift, exponent adjust, pack and flags.
  always_comb begin
    res_d   = FP24_PZERO;
    z_d     = 1'b0;
    o_d     = 1'b0;
    u_d     = 1'b0;
    e_inc   = {1'b0, a_q.exp} + 9'd1;
    shifted = a_q.mant << a_q.lzc[3:0];
    if (a_q.is_inf) begin
      res_d.sign = a_q.sign;
      res_d.exp  = EXP_MAX;
    end else if (a_q.is_zin) begin
      res_d.sign = a_q.sign;
      z_d        = 1'b1;
    end else if (a_q.eff_sub) begin
      if (a_q.lzc[4]) begin
        // Exact cancellation always yields +0.
        z_d = 1'b1;
      end else if ({3'b0, a_q.lzc} >= a_q.exp) begin
        // Would need exponent <= 0: flush to signed zero.
        res_d.sign = a_q.sign;
        z_d        = 1'b1;
        u_d        = 1'b1;
      end else begin
        res_d.sign = a_q.sign;
        res_d.exp  = a_q.exp - {3'b0, a_q.lzc};
        res_d.man  = shifted[14:0];
      end
    end else if (a_q.carry) begin
      res_d.sign = a_q.sign;
      if (e_inc[7:0] == EXP_MAX) begin
        res_d.exp = EXP_MAX;
        o_d       = 1'b1;
      end else begin
        res_d.exp = e_inc[7:0];
        res_d.man = a_q.mant[15:1];
      end
    end else begin
      res_d.sign = a_q.sign;
      res_d.exp  = a_q.exp;
      res_d.man  = a_q.mant[14:0];
    end
  end

  // Valid shift register; flush and reset kill both stages.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_pipe <= '0;
    end else begin
      if (b_adv) vld_pipe[2] <= vld_pipe[1];
      if (a_adv) vld_pipe[1] <= valid_i;
    end
  end

  // Stage A data register.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      a_q <= '0;
    else if (a_adv && valid_i)
      a_q <= a_d;
  end

  // Stage B data register; holds while stalled so outputs stay stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q <= FP24_PZERO;
      z_q   <= 1'b0;
      o_q   <= 1'b0;
      u_q   <= 1'b0;
    end else if (b_adv && vld_pipe[1]) begin
      res_q <= res_d;
      z_q   <= z_d;
      o_q   <= o_d;
      u_q   <= u_d;
    end
  end

  assign valid_o  = vld_pipe[2];
  assign result_o = res_q;
  assign zero_o   = z_q & vld_pipe[2];
  assign ovf_o    = o_q & vld_pipe[2];
  assign unf_o    = u_q & vld_pipe[2];

endmodule

// File: tb/tb_fp_std_1.sv
// Directed bench for fp_std_1: datapath vectors, back-pressure, flush, reset.
module tb_fp_std_1;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_o;
  logic        sign_i, eff_sub_i, valid_o, ready_i;
  logic [7:0]  exp_i;
  logic [16:0] add_mant_i;
  logic [15:0] sub_mant_i;
  logic [23:0] result_o;
  logic        zero_o, ovf_o, unf_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_std_1 #(.WIDTH(24)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .sign_i(sign_i), .exp_i(exp_i), .add_mant_i(add_mant_i),
    .sub_mant_i(sub_mant_i), .eff_sub_i(eff_sub_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .zero_o(zero_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] e,
                       input logic [16:0] am, input logic [15:0] sm, input logic es);
    valid_i = v; sign_i = s; exp_i = e; add_mant_i = am; sub_mant_i = sm; eff_sub_i = es;
  endtask

  task automatic chk_out(input string tag, input logic [23:0] r,
                         input logic z, input logic o, input logic u);
    chk({tag, ".valid"}, 32'(valid_o), 32'd1);
    chk({tag, ".res"},   32'(result_o), 32'(r));
    chk({tag, ".flags"}, {29'd0, zero_o, ovf_o, unf_o}, {29'd0, z, o, u});
  endtask

  // One op through an otherwise idle pipe: not visible after 1 edge, visible after 2.
  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [16:0] am, input logic [15:0] sm, input logic es,
                        input logic [23:0] r, input logic z, input logic o, input logic u);
    drive(1'b1, s, e, am, sm, es);
    tick();
    drive(1'b0, 1'b0, 8'd0, 17'd0, 16'd0, 1'b0);
    chk({tag, ".lat1"}, 32'(valid_o), 32'd0);
    tick();
    chk_out(tag, r, z, o, u);
    tick();
    chk({tag, ".drain"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 17'd0, 16'd0, 1'b0);
    tick(); tick();
    rst_i = 1'b0;
    #1;
    chk("rst.valid", 32'(valid_o), 32'd0);
    chk("rst.res",   32'(result_o), 32'd0);
    chk("rst.flags", {29'd0, zero_o, ovf_o, unf_o}, 32'd0);
    chk("rst.ready", 32'(ready_o), 32'd1);

    // Datapath vectors
    run_op("add_1p1",    1'b0, 8'd127, 17'h10000, 16'h0000, 1'b0, 24'h400000, 0, 0, 0);
    run_op("sub_1p5m1",  1'b0, 8'd127, 17'h00000, 16'h4000, 1'b1, 24'h3F0000, 0, 0, 0);
    run_op("ovf",        1'b0, 8'd254, 17'h10000, 16'h0000, 1'b0, 24'h7F8000, 0, 1, 0);
    run_op("cancel",     1'b1, 8'd127, 17'h00000, 16'h0000, 1'b1, 24'h000000, 1, 0, 0);
    run_op("unf",        1'b1, 8'd3,   17'h00000, 16'h0001, 1'b1, 24'h800000, 1, 0, 1);
    run_op("unf_eq",     1'b0, 8'd3,   17'h00000, 16'h1000, 1'b1, 24'h000000, 1, 0, 1);
    run_op("sub_min",    1'b0, 8'd4,   17'h00000, 16'h1000, 1'b1, 24'h008000, 0, 0, 0);
    run_op("sub_lzc3",   1'b0, 8'd10,  17'h00000, 16'h1234, 1'b1, 24'h0391A0, 0, 0, 0);
    run_op("add_nocar",  1'b0, 8'd127, 17'h0C000, 16'h0000, 1'b0, 24'h3FC000, 0, 0, 0);
    run_op("add_253",    1'b0, 8'd253, 17'h1FFFE, 16'h0000, 1'b0, 24'h7F7FFF, 0, 0, 0);
    run_op("inf_in",     1'b1, 8'd255, 17'h10000, 16'h0000, 1'b0, 24'hFF8000, 0, 0, 0);
    run_op("zero_in",    1'b1, 8'd0,   17'h10000, 16'h0000, 1'b0, 24'h800000, 1, 0, 0);

    // Back-pressure: 4-op stream, ready_i low across 3 edges.
    ready_i = 1'b0;
    drive(1'b1, 1'b0, 8'd127, 17'h10000, 16'h0000, 1'b0);   // op0 1+1
    tick();
    chk("bp.ready1", 32'(ready_o), 32'd1);
    drive(1'b1, 1'b0, 8'd127, 17'h00000, 16'h4000, 1'b1);   // op1 1.5-1
    tick();
    chk("bp.ready_full", 32'(ready_o), 32'd0);
    chk_out("bp.op0", 24'h400000, 0, 0, 0);
    drive(1'b1, 1'b0, 8'd10, 17'h00000, 16'h1234, 1'b1);    // op2 lzc3
    tick();
    chk_out("bp.hold1", 24'h400000, 0, 0, 0);
    chk("bp.ready_h1", 32'(ready_o), 32'd0);
    tick();
    chk_out("bp.hold2", 24'h400000, 0, 0, 0);
    ready_i = 1'b1;
    #1;
    chk("bp.ready_comb", 32'(ready_o), 32'd1);
    tick();
    chk_out("bp.op1", 24'h3F0000, 0, 0, 0);
    drive(1'b1, 1'b0, 8'd127, 17'h0C000, 16'h0000, 1'b0);   // op3 1.5
    tick();
    chk_out("bp.op2", 24'h0391A0, 0, 0, 0);
    drive(1'b0, 1'b0, 8'd0, 17'd0, 16'd0, 1'b0);
    tick();
    chk_out("bp.op3", 24'h3FC000, 0, 0, 0);
    tick();
    chk("bp.empty", 32'(valid_o), 32'd0);

    // Flush with two ops in flight and a simultaneous accept.
    drive(1'b1, 1'b0, 8'd254, 17'h10000, 16'h0000, 1'b0);   // overflow op
    tick();
    drive(1'b1, 1'b0, 8'd127, 17'h10000, 16'h0000, 1'b0);
    tick();
    flush_i = 1'b1;
    drive(1'b1, 1'b1, 8'd127, 17'h10000, 16'h0000, 1'b0);   // dropped
    #1;
    chk("fl.ready_comb", 32'(ready_o), 32'd1);
    tick();
    flush_i = 1'b0;
    chk("fl.valid0", 32'(valid_o), 32'd0);
    chk("fl.ovf_q", 32'(ovf_o), 32'd0);
    drive(1'b1, 1'b0, 8'd4, 17'h00000, 16'h1000, 1'b1);     // post-flush op
    tick();
    drive(1'b0, 1'b0, 8'd0, 17'd0, 16'd0, 1'b0);
    chk("fl.valid1", 32'(valid_o), 32'd0);
    tick();
    chk_out("fl.post", 24'h008000, 0, 0, 0);
    tick();
    chk("fl.nostale", 32'(valid_o), 32'd0);
    tick();
    chk("fl.nostale2", 32'(valid_o), 32'd0);

    // Reset mid-stream behaves like flush.
    drive(1'b1, 1'b0, 8'd127, 17'h10000, 16'h0000, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'd127, 17'h00000, 16'h4000, 1'b1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 17'd0, 16'd0, 1'b0);
    chk("mr.valid", 32'(valid_o), 32'd0);
    chk("mr.res",   32'(result_o), 32'd0);
    chk("mr.ready", 32'(ready_o), 32'd1);
    tick();
    chk("mr.nostale", 32'(valid_o), 32'd0);
    tick();
    chk("mr.nostale2", 32'(valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_std_1.md
# fp_std_1

Second stage of the fp24 add/sub datapath (1 sign, 8-bit exponent bias 127, 15-bit stored mantissa). It consumes the unnormalised intermediate from the alignment/add stage: sign, larger exponent, 17-bit sum mantissa and 16-bit difference mantissa. It selects the effective operation, normalises, handles exponent overflow/underflow and packs a final fp24 word. It is a 2-deep pipeline with valid/ready flow control and feeds the register-file writeback arbiter.

## Interface
- `WIDTH`, 24: packed float width; only 24 is supported.
- `clk_i`  in  1  core clock, all state on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  synchronous pipeline kill; drops all in-flight ops.
- `valid_i`  in  1  upstream intermediate valid.
- `ready_o`  out  1  stage can accept this cycle.
- `sign_i`  in  1  sign of the larger-magnitude operand.
- `exp_i`  in  8  larger exponent.
- `add_mant_i`  in  17  aligned sum mantissa, implicit bit at [15].
- `sub_mant_i`  in  16  aligned difference mantissa, implicit bit at [15].
- `eff_sub_i`  in  1  1 = use difference path, 0 = sum path.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  downstream accepts.
- `result_o`  out  WIDTH  packed fp24 result.
- `zero_o`, `ovf_o`, `unf_o`  out  1 each  result exactly zero / overflowed to inf / flushed from underflow.

## Operation
- Rounding is truncate (round toward zero). Subnormals are flushed to zero: any result exponent ≤ 0 becomes signed zero.
- Special input: if `exp_i`==255, output {sign_i, 8'hFF, 15'h0}. NaN is not distinguished. No flags are set.
- Special input: if `exp_i`==0, output {sign_i, 23'h0} with zero_o=1.
- Sum path, `add_mant_i[16]`=1: mantissa = add_mant_i[15:1], exponent = exp_i+1. If that exponent = 255, output {sign_i, 8'hFF, 15'h0} and ovf_o=1.
- Sum path, `add_mant_i[16]`=0: mantissa = add_mant_i[14:0], exponent = exp_i.
- Difference path, `sub_mant_i`==0: output +0 (sign forced 0), zero_o=1.
- Difference path, otherwise: lzc = leading zeros of sub_mant_i (0..15).
  - If lzc ≥ exp_i: output {sign_i, 23'h0}, unf_o=1, zero_o=1.
  - Else: exponent = exp_i − lzc, mantissa = (sub_mant_i << lzc)[14:0].
- Only one of ovf_o/unf_o can be set at a time. Flags are qualified by valid_o.

## Timing
- Stage A register: path select, lzc, special-case decode, carry bit.
- Stage B register: shift, exponent adjust, pack, flags.
- Latency is 2 cycles from accept (valid_i && ready_o) to valid_o. Throughput is 1 per cycle.
- Stage B advances when !B.valid or ready_i. Stage A advances when !A.valid or B advances. ready_o = A advances (combinational from ready_i).
- When valid_o && !ready_i: result_o and flags hold stable and no data is lost. Once the pipe is full, ready_o drops in the same cycle.
- flush_i clears both valids next edge. It has priority over a simultaneous accept, which is dropped. ready_o stays combinational.
- Reset values: A/B valid 0 → valid_o=0; result_o=0; zero_o=ovf_o=unf_o=0; ready_o=1 from the first cycle after reset.
- Reset asserted mid-operation: all in-flight ops are discarded, identical to flush.

## Structure
- Shared `fp_pkg`:
  - field widths: EXP_W=8, MAN_W=15, BIAS=127;
  - constants: EXP_MAX=8'hFF, FP24_PZERO;
  - a packed `fp24_t` struct {sign, exp, man}.
- One sub-module, `fp_lzc16`: a combinational 16-bit leading-zero counter with a 5-bit output (16 when input is 0). It is instantiated in stage A.

## Test plan
- 1.0+1.0: sign 0, exp 127, add_mant 0x10000, eff_sub 0 → result 0x400000 two cycles later, no flags.
- 1.5−1.0: exp 127, sub_mant 0x4000, eff_sub 1 → 0x3F0000 (0.5), lzc 1.
- Overflow: exp 254, add_mant 0x10000 → 0x7F8000, ovf_o=1. Cancellation: sub_mant 0 → 0x000000, zero_o=1.
- Underflow: exp 3, sub_mant 0x0001 → 0x000000 (sign per sign_i), unf_o=1.
- Back-pressure: stream 4 ops with ready_i low for 3 cycles mid-stream.
  - ready_o falls once 2 are held.
  - Outputs stay stable while stalled.
  - All 4 results emerge in order, with no duplicates.
- flush_i with 2 ops in flight, plus rst_i mid-stream → valid_o=0 next cycle, no stale result ever emitted; an op accepted the cycle after flush completes normally.
